// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader.
// The skid buffer depth sets both the occupancy full code and the
// read-issue limit used by the top.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned SKID_DEPTH = 2;

    // Occupancy code when every skid entry holds a word.
    localparam logic [1:0] OCC_FULL = 2'(SKID_DEPTH);

    // A new read may only be issued while the projected slot usage is below this.
    localparam logic [2:0] SLOT_LIMIT = 3'(SKID_DEPTH);

    // Skid slots that will be committed at the end of this cycle:
    // words already buffered plus the word returning from last cycle's read,
    // minus the word leaving on the stream this cycle.
    function automatic logic [2:0] slots_after(
        input logic [1:0] occ,
        input logic       inflight,
        input logic       pop
    );
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order buffer that catches words returning from the FIFO's
// registered read port. Entry 0 is always the head; a pop shifts entry 1 down.
// Push and pop in the same cycle keep occupancy unchanged and preserve order.
module fifo_rd_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] ent0_q;
    logic [DATA_W-1:0] ent0_d;
    logic [DATA_W-1:0] ent1_q;
    logic [DATA_W-1:0] ent1_d;
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;
    logic              pop_ok_s;
    logic              push_ok_s;

    // Ignore pops from an empty buffer and pushes into a full one that is not draining.
    always_comb begin
        pop_ok_s  = pop && (occ_q != 2'd0);
        push_ok_s = push && ((occ_q != OCC_FULL) || pop_ok_s);
    end

    // Entry and occupancy update for push, pop, or both together.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({push_ok_s, pop_ok_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    ent0_d = push_data;
                end else begin
                    ent1_d = push_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == OCC_FULL) begin
                    ent0_d = ent1_q;
                end else begin
                    ent0_d = '0;
                end
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == OCC_FULL) begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end else begin
                    ent0_d = push_data;
                end
                occ_d = occ_q;
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Buffer storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = ent0_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for the synchronous FIFO. Takes a word-count command,
// drains exactly that many words through the FIFO read port, and streams them
// out with m_last on the final beat. Reads are throttled so the returning
// words always fit in the two-entry skid buffer.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    input  logic              fifo_underflow,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              done,
    output logic              busy,
    output logic              err_underflow
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_e            state_q;
    state_e            state_d;
    logic [LEN_W-1:0]  rd_left_q;
    logic [LEN_W-1:0]  rd_left_d;
    logic [LEN_W-1:0]  beat_left_q;
    logic [LEN_W-1:0]  beat_left_d;
    logic              inflight_q;
    logic              inflight_d;
    logic              err_q;
    logic              err_d;

    logic [1:0]        occ_s;
    logic [DATA_W-1:0] head_s;
    logic              m_valid_s;
    logic              pop_s;
    logic              hs_s;
    logic              rd_en_s;
    logic              cmd_ready_s;
    logic              busy_s;
    logic              done_s;

    fifo_rd_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (fifo_rd_data),
        .pop       (pop_s),
        .occ       (occ_s),
        .head      (head_s)
    );

    // Stream-side handshake: a beat leaves whenever the skid head is presented and accepted.
    always_comb begin
        m_valid_s = (occ_s != 2'd0);
        pop_s     = m_valid_s && m_ready;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a zero-length command skips straight to the done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (rd_en_s && (rd_left_q == LEN_ONE)) begin
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (pop_s && (beat_left_q == LEN_ONE)) begin
                    state_d = DONE;
                end else begin
                    state_d = FLUSH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs and read issue: never read an empty FIFO or overfill the skid.
    always_comb begin
        cmd_ready_s = (state_q == IDLE);
        busy_s      = (state_q != IDLE);
        done_s      = (state_q == DONE);
        hs_s        = cmd_valid && cmd_ready_s;
        if ((state_q == RUN) && (rd_left_q != '0) && !fifo_empty &&
            (slots_after(occ_s, inflight_q, pop_s) < SLOT_LIMIT)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Burst counters, in-flight marker and sticky underflow error.
    always_comb begin
        rd_left_d   = rd_left_q;
        beat_left_d = beat_left_q;
        inflight_d  = rd_en_s;
        err_d       = err_q || (fifo_underflow && rd_en_s);
        if (hs_s) begin
            rd_left_d   = cmd_len;
            beat_left_d = cmd_len;
        end else begin
            if (rd_en_s && (rd_left_q != '0)) begin
                rd_left_d = rd_left_q - LEN_ONE;
            end else begin
                rd_left_d = rd_left_q;
            end
            if (pop_s && (beat_left_q != '0)) begin
                beat_left_d = beat_left_q - LEN_ONE;
            end else begin
                beat_left_d = beat_left_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_left_q   <= '0;
            beat_left_q <= '0;
            inflight_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rd_left_q   <= rd_left_d;
            beat_left_q <= beat_left_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready     = cmd_ready_s;
    assign busy          = busy_s;
    assign done          = done_s;
    assign fifo_rd_en    = rd_en_s;
    assign m_valid       = m_valid_s;
    assign m_data        = head_s;
    assign m_last        = m_valid_s && (beat_left_q == LEN_ONE);
    assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a behavioural FIFO feeds the DUT, and a
// queue-based model predicts the beat stream from the command lengths and
// the order in which words were written.
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data = '0;
    logic              fifo_empty = 1'b1;
    logic              fifo_underflow;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              done;
    logic              busy;
    logic              err_underflow;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              uf_inj;
    logic              uf_q = 1'b0;
    logic [DATA_W-1:0] fq[$];
    int                rdy_mode = 0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] wq[$];
    logic [DATA_W-1:0] expq[$];
    logic              lastq[$];
    int                owed = 0;
    int                outstanding = 0;
    logic              done_due = 1'b0;
    logic              stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;
    logic              stall_last = 1'b0;
    logic [DATA_W-1:0] e_data;
    logic              e_last;
    int cyc = 0;
    int first_rd = -1, last_rd = -1, first_v = -1, last_cyc = -1;
    int burst_rds = 0, burst_beats = 0, last_cnt = 0, done_cnt = 0, beat_total = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_len        (cmd_len),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .done           (done),
        .busy           (busy),
        .err_underflow  (err_underflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural FIFO: registered data_out, combinational-style empty flag.
    always @(posedge clk) begin
        uf_q <= 1'b0;
        if (fifo_rd_en) begin
            if (fq.size() == 0) uf_q <= 1'b1;
            else fifo_rd_data <= fq.pop_front();
        end
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end
    assign fifo_underflow = uf_q | uf_inj;

    // Sink ready pattern: always, 1-0-0 repeating, or random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 3) == 0);
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
        endcase
    end

    // Reference model and monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            expq.delete();
            lastq.delete();
            wq          = fq;
            owed        = 0;
            outstanding = 0;
            done_due    = 1'b0;
            stall_prev  = 1'b0;
        end else begin
            check_eq("done_pulse", 32'(done), 32'(done_due));
            if (done) done_cnt++;
            done_due = 1'b0;
            if (wr_en) begin
                if (owed > 0) begin
                    expq.push_back(wr_data);
                    lastq.push_back(owed == 1);
                    owed--;
                end else begin
                    wq.push_back(wr_data);
                end
            end
            if (!m_valid) check_eq("last_unqualified", 32'(m_last), 32'd0);
            if (stall_prev) begin
                check_eq("stall_valid", 32'(m_valid), 32'd1);
                check_eq("stall_data", 32'(m_data), 32'(stall_data));
                check_eq("stall_last", 32'(m_last), 32'(stall_last));
            end
            if (fifo_rd_en) begin
                check_eq("rd_when_empty", 32'(fifo_empty), 32'd0);
                outstanding++;
                burst_rds++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready) begin
                outstanding--;
                burst_beats++;
                beat_total++;
                check_eq("beat_expected", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    e_data = expq.pop_front();
                    e_last = lastq.pop_front();
                    check_eq("m_data", 32'(m_data), 32'(e_data));
                    check_eq("m_last", 32'(m_last), 32'(e_last));
                    if (m_last) last_cnt++;
                    if (e_last) begin
                        done_due = 1'b1;
                        last_cyc = cyc;
                    end
                end
            end
            check_eq("skid_bound", 32'(outstanding <= 2), 32'd1);
            check_eq("read_overrun", 32'(outstanding <= expq.size() + owed), 32'd1);
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
            if (cmd_valid && cmd_ready) begin
                first_rd = -1; last_rd = -1; first_v = -1;
                burst_rds = 0; burst_beats = 0;
                if (cmd_len == '0) begin
                    done_due = 1'b1;
                end else begin
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        if (wq.size() > 0) begin
                            expq.push_back(wq.pop_front());
                            lastq.push_back(i == int'(cmd_len) - 1);
                        end else begin
                            owed++;
                        end
                    end
                end
            end
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_words(input int n, input logic [DATA_W-1:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = rnd ? 16'($urandom) : base + 16'(i);
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic send_cmd(input int len);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        @(negedge clk);
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        @(negedge clk);
        #2;
        while ((busy || expq.size() != 0 || owed != 0) && t < 1000) begin
            @(negedge clk);
            #2;
            t++;
        end
        check_eq(tag, 32'(busy || expq.size() != 0 || owed != 0), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check_eq({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        check_eq({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check_eq({tag, "_m_data"}, 32'(m_data), 32'd0);
        check_eq({tag, "_m_last"}, 32'(m_last), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_err"}, 32'(err_underflow), 32'd0);
    endtask

    // Bound the whole run.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc0, dc0, bt0, pre, len, t;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
        wr_en = 1'b0; wr_data = '0; uf_inj = 1'b0;
        #1;
        check_reset_outputs("rst0");
        cyc_wait(2);
        rst_n = 1'b1;
        cyc_wait(1);

        // Four-word burst at full rate.
        write_words(4, 16'hA001, 1'b0);
        cyc_wait(1);
        send_cmd(4);
        wait_idle("t1_idle");
        check_eq("t1_reads", 32'(burst_rds), 32'd4);
        check_eq("t1_rd_consec", 32'(last_rd - first_rd), 32'd3);
        check_eq("t1_latency", 32'(first_v - first_rd), 32'd2);
        check_eq("t1_span", 32'(last_cyc - first_v), 32'd3);
        check_eq("t1_err", 32'(err_underflow), 32'd0);

        // Eight words under 1-0-0 backpressure.
        write_words(8, 16'hB001, 1'b0);
        lc0 = last_cnt;
        rdy_mode = 1;
        send_cmd(8);
        wait_idle("t2_idle");
        rdy_mode = 0;
        check_eq("t2_beats", 32'(burst_beats), 32'd8);
        check_eq("t2_one_last", 32'(last_cnt - lc0), 32'd1);

        // FIFO runs dry mid-burst, refilled later.
        write_words(2, 16'hC001, 1'b0);
        send_cmd(5);
        cyc_wait(10);
        write_words(3, 16'hC003, 1'b0);
        wait_idle("t3_idle");
        check_eq("t3_beats", 32'(burst_beats), 32'd5);
        check_eq("t3_err", 32'(err_underflow), 32'd0);

        // Zero-length command.
        send_cmd(0);
        @(negedge clk);
        #2;
        check_eq("t4_done_ready", 32'(cmd_ready), 32'd0);
        check_eq("t4_done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #2;
        check_eq("t4_ready_back", 32'(cmd_ready), 32'd1);
        check_eq("t4_no_reads", 32'(burst_rds), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a six-word burst.
        write_words(10, 16'hD001, 1'b0);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(6);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        t = 0;
        @(negedge clk);
        #2;
        while (burst_beats < 2 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        check_eq("t5_two_beats", 32'(burst_beats), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        cyc_wait(2);
        rst_n = 1'b1;
        cyc_wait(1);
        send_cmd(3);
        wait_idle("t5_idle");
        check_eq("t5_beats", 32'(burst_beats), 32'd3);
        if (fq.size() > 0) begin
            send_cmd(fq.size());
            wait_idle("t5_drain");
        end

        // Back-to-back commands with cmd_valid held high.
        write_words(5, 16'hE001, 1'b0);
        lc0 = last_cnt; dc0 = done_cnt; bt0 = beat_total;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(3);
        @(negedge clk);
        @(posedge clk);
        #1;
        cmd_len = LEN_W'(2);
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("t6_second_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle("t6_idle");
        check_eq("t6_beats", 32'(beat_total - bt0), 32'd5);
        check_eq("t6_lasts", 32'(last_cnt - lc0), 32'd2);
        check_eq("t6_dones", 32'(done_cnt - dc0), 32'd2);

        // Random bursts with random backpressure and late writes.
        rdy_mode = 2;
        for (int k = 0; k < 10; k++) begin
            len = int'($urandom_range(1, 12));
            pre = int'($urandom_range(0, 32'(len)));
            write_words(pre, '0, 1'b1);
            send_cmd(len);
            cyc_wait(int'($urandom_range(0, 5)));
            write_words(len - pre, '0, 1'b1);
            wait_idle("rnd_idle");
            check_eq("rnd_beats", 32'(burst_beats), 32'(len));
        end
        rdy_mode = 0;

        // Underflow flag seen during a read sets the sticky error.
        check_eq("t8_err_clear", 32'(err_underflow), 32'd0);
        write_words(2, 16'hF001, 1'b0);
        uf_inj = 1'b1;
        send_cmd(2);
        wait_idle("t8_idle");
        uf_inj = 1'b0;
        check_eq("t8_err_set", 32'(err_underflow), 32'd1);
        write_words(1, 16'hF003, 1'b0);
        send_cmd(1);
        wait_idle("t8_idle2");
        check_eq("t8_err_sticky", 32'(err_underflow), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t8_err_reset", 32'(err_underflow), 32'd0);
        cyc_wait(1);
        rst_n = 1'b1;
        cyc_wait(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side master for the team's synchronous FIFO. Accepts a burst command (word count), drains exactly that many words through the FIFO read port (rd_en / registered data_out / empty), and presents them on a valid/ready stream with m_last on the final beat. It never issues a read while the FIFO is empty, absorbs the FIFO's 1-cycle read latency with a 2-entry skid buffer, and sustains 1 word/cycle under no backpressure.

Parameters:
DATA_W, 16, word width; matches FIFO_WIDTH of the attached FIFO
LEN_W, 8, width of cmd_len; max burst is 2^LEN_W-1 words

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  burst request valid
cmd_ready  out  1  high only in IDLE; handshake is cmd_valid&cmd_ready
cmd_len  in  LEN_W  words to drain; sampled on handshake
fifo_rd_en  out  1  FIFO read enable; asserted only when fifo_empty=0
fifo_rd_data  in  DATA_W  FIFO data_out; valid the cycle after fifo_rd_en
fifo_empty  in  1  FIFO empty flag (combinational from FIFO count)
fifo_underflow  in  1  FIFO underflow flag
m_valid  out  1  stream data valid
m_ready  in  1  stream sink ready; beat transfers on m_valid&m_ready
m_data  out  DATA_W  stream data
m_last  out  1  high on final beat of burst, qualified by m_valid
done  out  1  1-cycle pulse after last beat transfers
busy  out  1  high in any state other than IDLE
err_underflow  out  1  sticky: set if fifo_underflow=1 while fifo_rd_en=1; cleared only by reset

Behaviour:
- Reset (async): state IDLE; counters, skid occupancy and in-flight flag cleared; cmd_ready=1, fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, done=0, busy=0, err_underflow=0. FIFO contents not affected. Reset mid-burst discards in-flight and buffered words with no done pulse.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: cmd handshake with cmd_len>0 -> RUN; rd_left=cmd_len, beat_left=cmd_len. cmd_len=0 -> DONE directly, no reads, no beats.
- RUN: fifo_rd_en = (rd_left!=0) && !fifo_empty && (occ + inflight - pop) < 2. occ = skid entries (0..2), inflight = rd_en issued last cycle, pop = m_valid&m_ready this cycle. Each read decrements rd_left. rd_left reaches 0 -> FLUSH.
- Read data path: fifo_rd_en at cycle t; fifo_rd_data captured into the skid at end of t+1; m_valid high in t+2 at the earliest (2-cycle read-to-valid latency). Skid is FIFO-ordered; m_data = head entry.
- Throughput: with m_ready=1 and FIFO non-empty, one beat per cycle in steady state.
- FIFO empty mid-burst: rd_en held low, rd_left held, buffered beats still drain; resumes the cycle fifo_empty falls. No timeout.
- Backpressure: m_valid/m_data/m_last stable while m_valid&!m_ready; rd_en throttled by the occupancy rule; skid never overflows (occ+inflight<=2 invariant).
- m_last = m_valid && beat_left==1. beat_left decrements on each transfer.
- FLUSH: no reads; on transfer with beat_left==1 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. cmd_ready=0 in DONE, so the earliest next handshake is the cycle after done.
- Simultaneous push (from in-flight read) and pop in the same cycle: occ unchanged, order preserved.
- Width: occ 2 bits, rd_left/beat_left LEN_W bits, never wrap (decrement only when nonzero).

Decomposition:
- Package fifo_burst_reader_pkg: state enum (IDLE, RUN, FLUSH, DONE), SKID_DEPTH=2 constant.
- Sub-module fifo_rd_skid_buf: 2-entry registered buffer with push/pop/occ/head outputs; the top holds the FSM, counters and read-issue logic.

Test Plan:
- FIFO preloaded 0xA001..0xA004, cmd_len=4, m_ready=1 -> rd_en on 4 consecutive cycles; m_data A001..A004 on 4 consecutive cycles starting 2 cycles after the first rd_en; m_last on A004; done the cycle after; err_underflow=0.
- Preload 8 words, cmd_len=8, m_ready toggling 1,0,0,1... -> all 8 words in order, data stable while stalled, rd_en never when occ+inflight-pop>=2, exactly one m_last.
- FIFO holds 2 words, cmd_len=5, 3 more written 10 cycles later -> 2 beats, gap with rd_en=0 while empty, then 3 beats; m_last on 5th; no underflow.
- cmd_len=0 -> no rd_en, no m_valid; done pulses 1 cycle after the handshake; cmd_ready returns high the next cycle.
- Reset asserted after 2 of 6 beats -> all outputs take reset values immediately; a new cmd_len=3 reads the next 3 FIFO words correctly.
- Back-to-back cmds len 3 then 2 (cmd_valid held high) -> 5 beats in order, m_last on beats 3 and 5, two done pulses.
